knn_selector: RTL and testbench

- Streaming K-nearest selector. Sits directly upstream of the coordinate-averaging stage.
- Accepts one (distance, label) sample per cycle from the distance calculator for one query frame.
- Keeps the K_NUM smallest distances in a sorted register array.
- At frame end, publishes the K_NUM labels as a held array consumed by the averager's per-index label inputs.

---
 rtl/knn_selector_if.sv | 28 ++
 rtl/knn_selector.sv | 102 ++++++++++
 tb/tb_knn_selector.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/knn_selector_if.sv
// Stream interface of the K-nearest selector: (distance, label) samples in,
// held array of K nearest labels plus publish pulse out.
interface knn_selector_if #(
  parameter int LBL_LEN  = 10,
  parameter int K_NUM    = 5,
  parameter int DIST_LEN = 12
);
  localparam int CNT_W = $clog2(K_NUM + 1);

  logic                in_valid;
  logic                in_ready;
  logic [DIST_LEN-1:0] in_dist;
  logic [LBL_LEN-1:0]  in_lbl;
  logic                in_last;
  logic [LBL_LEN-1:0]  outL [K_NUM];
  logic                out_valid;
  logic [CNT_W-1:0]    out_count;

  modport master (
    output in_valid, in_dist, in_lbl, in_last,
    input  in_ready, outL, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_dist, in_lbl, in_last,
    output in_ready, outL, out_valid, out_count
  );
endinterface

// File: rtl/knn_selector.sv
// Streaming K-nearest selector: keeps the K_NUM smallest distances of a frame
// in a sorted slot array and publishes their labels when the frame ends.
module knn_selector #(
  parameter int LBL_LEN  = 10,
  parameter int K_NUM    = 5,
  parameter int DIST_LEN = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  knn_selector_if.slave  bus
);
  localparam int CNT_W = $clog2(K_NUM + 1);

  typedef enum logic {S_COLLECT, S_PUBLISH} state_t;

  state_t              state;
  logic [DIST_LEN-1:0] slot_dist [K_NUM];
  logic [LBL_LEN-1:0]  slot_lbl  [K_NUM];
  logic [K_NUM-1:0]    slot_valid;
  logic [CNT_W-1:0]    count;
  logic [K_NUM-1:0]    lt;
  logic                accept;

  assign accept = bus.in_valid && bus.in_ready;

  // An empty slot always accepts, so an all-ones distance still finds a home.
  always_comb begin
    lt = '0;
    for (int i = 0; i < K_NUM; i++) begin
      lt[i] = (bus.in_dist < slot_dist[i]) || !slot_valid[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_COLLECT;
      count         <= '0;
      slot_valid    <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_count <= '0;
      for (int i = 0; i < K_NUM; i++) begin
        slot_dist[i] <= '1;
        slot_lbl[i]  <= '0;
        bus.outL[i]  <= '0;
      end
    end else begin
      case (state)
        S_COLLECT: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          if (accept) begin
            // Parallel compare-shift: the last slot's entry falls off the end.
            if (lt[0]) begin
              slot_dist[0]  <= bus.in_dist;
              slot_lbl[0]   <= bus.in_lbl;
              slot_valid[0] <= 1'b1;
            end
            for (int i = 1; i < K_NUM; i++) begin
              if (lt[i-1]) begin
                slot_dist[i]  <= slot_dist[i-1];
                slot_lbl[i]   <= slot_lbl[i-1];
                slot_valid[i] <= slot_valid[i-1];
              end else if (lt[i]) begin
                slot_dist[i]  <= bus.in_dist;
                slot_lbl[i]   <= bus.in_lbl;
                slot_valid[i] <= 1'b1;
              end
            end
            if (count != CNT_W'(K_NUM)) begin
              count <= count + 1'b1;
            end
            if (bus.in_last) begin
              state        <= S_PUBLISH;
              bus.in_ready <= 1'b0;
            end
          end
        end

        S_PUBLISH: begin
          // Unfilled entries repeat the nearest label so a divide-by-K average
          // downstream stays inside the real label cluster.
          for (int i = 0; i < K_NUM; i++) begin
            bus.outL[i]  <= slot_valid[i] ? slot_lbl[i] : slot_lbl[0];
            slot_dist[i] <= '1;
            slot_lbl[i]  <= '0;
          end
          bus.out_count <= count;
          bus.out_valid <= 1'b1;
          slot_valid    <= '0;
          count         <= '0;
          bus.in_ready  <= 1'b1;
          state         <= S_COLLECT;
        end

        default: begin
          state <= S_COLLECT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_knn_selector.sv
// Self-checking bench for knn_selector: directed frames plus randomized frames
// compared against a stable selection-sort reference model.
module tb_knn_selector;
  localparam int LBL_LEN  = 10;
  localparam int K_NUM    = 5;
  localparam int DIST_LEN = 12;
  localparam int CNT_W    = $clog2(K_NUM + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors      = 0;
  int checks      = 0;
  int pulses_seen = 0;
  int pulses_exp  = 0;

  int                 frame_d [$];
  int                 frame_l [$];
  logic [LBL_LEN-1:0] held_lbl [K_NUM];
  int                 held_cnt;

  knn_selector_if #(.LBL_LEN(LBL_LEN), .K_NUM(K_NUM), .DIST_LEN(DIST_LEN)) bus ();

  knn_selector #(.LBL_LEN(LBL_LEN), .K_NUM(K_NUM), .DIST_LEN(DIST_LEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) pulses_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stable selection of the K smallest: strict less-than keeps the earliest of equals.
  task automatic publishModel();
    bit taken [64];
    int n;
    int best;
    n = frame_d.size();
    for (int j = 0; j < 64; j++) taken[j] = 1'b0;
    for (int k = 0; k < K_NUM; k++) begin
      best = -1;
      for (int j = 0; j < n; j++) begin
        if (!taken[j] && (best < 0 || frame_d[j] < frame_d[best])) best = j;
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        held_lbl[k] = LBL_LEN'(frame_l[best]);
      end else begin
        held_lbl[k] = held_lbl[0];
      end
    end
    held_cnt = (n < K_NUM) ? n : K_NUM;
    frame_d.delete();
    frame_l.delete();
    pulses_exp++;
  endtask

  task automatic clearModel();
    frame_d.delete();
    frame_l.delete();
    for (int i = 0; i < K_NUM; i++) held_lbl[i] = '0;
    held_cnt = 0;
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < K_NUM; i++) begin
      check($sformatf("%s_outL%0d", tag, i), 32'(bus.outL[i]), 32'(held_lbl[i]));
    end
    check({tag, "_count"}, 32'(bus.out_count), 32'(held_cnt));
  endtask

  // Drives one sample from a negedge, waits (bounded) for in_ready, returns at the
  // negedge after the accepting edge.
  task automatic applyStimulus(input int d, input int l, input bit last, input bit keep,
                               output int waited);
    bus.in_valid = 1'b1;
    bus.in_dist  = DIST_LEN'(d);
    bus.in_lbl   = LBL_LEN'(l);
    bus.in_last  = last;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    frame_d.push_back(d);
    frame_l.push_back(l);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic publishCheck(input string tag);
    check({tag, "_ready_low"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_no_early_pulse"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.out_valid), 32'd1);
    publishModel();
    checkOutput(tag);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_hold"});
  endtask

  initial begin
    int w;
    int n;
    int d1 [7] = '{9, 3, 7, 1, 8, 2, 6};
    int exp1 [5] = '{'h004, 'h006, 'h002, 'h007, 'h003};
    int exp3 [5] = '{'h0B2, 'h0A1, 'h0B2, 'h0B2, 'h0B2};
    int saved [K_NUM];

    bus.in_valid = 1'b0;
    bus.in_dist  = '0;
    bus.in_lbl   = '0;
    bus.in_last  = 1'b0;
    clearModel();

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);

    $display("[TB] basic frame");
    for (int i = 0; i < 7; i++) applyStimulus(d1[i], i + 1, i == 6, 1'b0, w);
    publishCheck("basic");
    for (int i = 0; i < K_NUM; i++)
      check($sformatf("basic_const%0d", i), 32'(bus.outL[i]), 32'(exp1[i]));

    $display("[TB] tie frame");
    for (int i = 0; i < 6; i++) applyStimulus(5, 'h0A + i, i == 5, 1'b0, w);
    publishCheck("tie");

    $display("[TB] short frame");
    applyStimulus(4, 'h0A1, 1'b0, 1'b0, w);
    applyStimulus(2, 'h0B2, 1'b1, 1'b0, w);
    publishCheck("short");
    for (int i = 0; i < K_NUM; i++)
      check($sformatf("short_const%0d", i), 32'(bus.outL[i]), 32'(exp3[i]));
    check("short_const_count", 32'(bus.out_count), 32'd2);

    $display("[TB] back-to-back frames");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(20 - i, 'h100 + i, i == 3, 1'b1, w);
      if (i > 0) check("b2b_a_nowait", 32'(w), 32'd0);
    end
    check("b2b_ready_low", 32'(bus.in_ready), 32'd0);
    check("b2b_no_early_pulse", 32'(bus.out_valid), 32'd0);
    bus.in_dist = DIST_LEN'(7);
    bus.in_lbl  = LBL_LEN'('h1F0);
    @(negedge clk);
    check("b2b_ready_back", 32'(bus.in_ready), 32'd1);
    check("b2b_pulse", 32'(bus.out_valid), 32'd1);
    publishModel();
    checkOutput("b2b_pub");
    for (int i = 0; i < K_NUM; i++) saved[i] = int'(held_lbl[i]);
    @(posedge clk);
    frame_d.push_back(7);
    frame_l.push_back('h1F0);
    @(negedge clk);
    check("b2b_pulse_end", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(i * 3, 'h1F0 + i, i == 5, 1'b1, w);
      check("b2b_b_nowait", 32'(w), 32'd0);
      if (i == 4)
        for (int k = 0; k < K_NUM; k++)
          check($sformatf("b2b_hold%0d", k), 32'(bus.outL[k]), 32'(saved[k]));
    end
    bus.in_valid = 1'b0;
    publishCheck("b2b_second");

    $display("[TB] all-ones distances");
    applyStimulus('hFFF, 'h2AA, 1'b0, 1'b0, w);
    applyStimulus('hFFF, 'h155, 1'b1, 1'b0, w);
    publishCheck("ones");

    $display("[TB] randomized frames");
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_last  = 1'($urandom_range(0, 1));
          bus.in_dist  = DIST_LEN'($urandom);
          @(negedge clk);
        end
        applyStimulus(($urandom_range(0, 7) == 0) ? 'hFFF : $urandom_range(0, 15),
                      $urandom_range(0, 1023), i == n - 1, 1'b0, w);
      end
      publishCheck($sformatf("rand%0d", f));
    end

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(10 + i, 'h0C0 + i, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    #1;
    clearModel();
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_pulse", 32'(bus.out_valid), 32'd0);
    applyStimulus(0, 'h155, 1'b1, 1'b0, w);
    publishCheck("after_rst");
    for (int i = 0; i < K_NUM; i++)
      check($sformatf("after_rst_const%0d", i), 32'(bus.outL[i]), 32'h155);
    check("after_rst_const_count", 32'(bus.out_count), 32'd1);

    repeat (2) @(negedge clk);
    check("pulse_total", 32'(pulses_seen), 32'(pulses_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
